udp_writer: RTL and testbench
=============================

# udp_writer

Transmit-side payload source for `udp_packet`, the counterpart of `udp_reader`. It captures a CAPACITY-byte parallel word, such as a box-report or status record, on a load strobe and issues a one-cycle `trig` to `udp_packet`. It then serves payload bytes one per `read_en`, in the same byte order `udp_reader` uses on receive. It runs in the `rgmii_clk` domain, beside `udp_reader`.

## Interface
- `CAPACITY`, 6: payload bytes per packet, ≥1.
- `TIMEOUT`, 65535: idle cycles allowed in ARM/SEND without `read_en` before abort; 0 disables the timeout.
- `clk` in 1: clock (`rgmii_clk` at top level).
- `rstn` in 1: reset, asynchronous, active-low.
- `load` in 1: capture `i_data` and start a packet (accepted in IDLE only).
- `i_data` in CAPACITY*8: payload; byte k = `i_data[8k+7:8k]`, byte 0 sent first.
- `trig` out 1: one-cycle start pulse to `udp_packet`.
- `read_en` in 1: byte consume strobe from `udp_packet` `tx_read_en`.
- `o_data` out 8: current payload byte, show-ahead.
- `o_len` out 16: payload length in bytes, constant LEN.
- `busy` out 1: high in ARM and SEND.
- `error` out 1: one-cycle pulse on dropped load, stray read, or timeout.

## Operation
- LEN = CAPACITY, or CAPACITY+1 with the checksum option. `o_len` = LEN, zero-extended to 16 bits.
- States and transitions:
  - IDLE: `load` latches `i_data` into the shift register, ptr←0, `o_data`←byte 0; go to ARM.
  - ARM: `trig`=1 for this single cycle; next state is SEND.
  - SEND: waits for `read_en`.
- Read handling in ARM or SEND:
  - On `read_en` with ptr<LEN-1: ptr←ptr+1, `o_data`←byte ptr+1, timeout counter cleared.
  - On `read_en` with ptr=LEN-1: go to IDLE, `o_data`←0.
- Timeout: the counter increments each ARM/SEND cycle without `read_en`. When it reaches TIMEOUT, go to IDLE, `o_data`←0, pulse `error`.
- Error sources:
  - `load` while `busy`: ignored, `error` pulses. This includes `load` in the same cycle as the final `read_en`.
  - `read_en` in IDLE: ignored, `o_data` stays 0, `error` pulses.
- Simultaneous `read_en` and timeout expiry: `read_en` wins and the counter clears.
- `i_data` is sampled only on the accepted `load`; later changes do not affect a packet in flight.
- Reset mid-packet: immediate return to IDLE with all outputs at reset values. No `trig` is reissued.

## Timing
- Reset values: `trig`=0, `o_data`=0, `busy`=0, `error`=0, state IDLE, ptr=0, counter=0. `o_len` is constant.
- `load` accepted at edge N: edge N+1 enters ARM (`trig`=1, `busy`=1, `o_data`=byte 0). Edge N+2 enters SEND (`trig`=0).
- Show-ahead: `o_data` holds byte ptr before the edge that samples `read_en`, and holds the next byte one cycle later.
- Final `read_en` at edge M: `busy`=0 and `o_data`=0 from edge M onward. A new `load` is accepted at edge M+1 or later.
- Back-to-back `read_en` every cycle is supported: throughput 1 byte/cycle.
- `error` is registered and pulses one cycle after the offending input edge.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- Macro `UDP_WRITER_CHKSUM_EN`.
- Defined:
  - LEN = CAPACITY+1.
  - Byte CAPACITY is the XOR of bytes 0..CAPACITY-1, computed at `load` and sent last.
  - `o_len` = CAPACITY+1.
- Undefined: LEN = CAPACITY, no checksum byte, and no checksum logic is instantiated.

## Test plan
- Basic send:
  - Stimulus: CAPACITY=6, `i_data`=48'h665544332211, `load` for 1 cycle, `read_en` held high from the first SEND cycle.
  - Response: exactly one `trig`; `o_data` sequence 11,22,33,44,55,66; `busy` falls after the 6th read; `o_len`=6; no `error`.
- Checksum:
  - Stimulus: same as basic send, with `UDP_WRITER_CHKSUM_EN` defined.
  - Response: 7 bytes ending in 0x77; `o_len`=7.
- Gapped reads plus overlapping load:
  - Stimulus: `read_en` asserted every 3rd cycle, with a `load` of 48'hFFFFFFFFFFFF mid-packet.
  - Response: original bytes unchanged; one `error` pulse; no second `trig`.
- Stray read:
  - Stimulus: `read_en` in IDLE.
  - Response: `error` pulse one cycle later; `o_data`=0; state remains IDLE.
- Timeout:
  - Stimulus: TIMEOUT=10, `load`, then no `read_en`.
  - Response: after 10 ARM/SEND cycles, `busy`=0 and one `error` pulse. A following `load` produces a normal packet.
- Reset mid-packet:
  - Stimulus: `rstn` low after 3 of 6 bytes have been read.
  - Response: all outputs 0 asynchronously. After release, `load` of 48'h0A0B0C0D0E0F yields 0F,0E,0D,0C,0B,0A.

Source files
------------

// File: rtl/udp_writer.sv
// udp_writer: transmit-side payload source for udp_packet (rgmii_clk domain).
// Captures a CAPACITY-byte word on load, pulses trig for one cycle, then
// serves one payload byte per read_en, byte 0 first (show-ahead on o_data).
// An idle timeout aborts a packet that udp_packet never drains.
//
// Optional feature macro: UDP_WRITER_CHKSUM_EN
//   defined   -> an XOR checksum byte of the payload is appended (LEN = CAPACITY+1)
//   undefined -> LEN = CAPACITY, no checksum logic
//
// Ports:
//   clk      in  : clock (rgmii_clk)
//   rstn     in  : asynchronous active-low reset
//   load     in  : capture i_data and start a packet (accepted in IDLE only)
//   i_data   in  : payload, byte k = i_data[8k+7:8k]
//   trig     out : one-cycle start pulse to udp_packet
//   read_en  in  : byte consume strobe (udp_packet tx_read_en)
//   o_data   out : current payload byte, show-ahead
//   o_len    out : payload length in bytes (constant)
//   busy     out : packet in flight (ARM or SEND)
//   error    out : one-cycle pulse on dropped load, stray read or timeout
module udp_writer #(
  parameter int unsigned CAPACITY = 6,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [CAPACITY*8-1:0] i_data,
  output logic                  trig,
  input  logic                  read_en,
  output logic [7:0]            o_data,
  output logic [15:0]           o_len,
  output logic                  busy,
  output logic                  error
);

`ifdef UDP_WRITER_CHKSUM_EN
  localparam int unsigned LEN = CAPACITY + 1;
`else
  localparam int unsigned LEN = CAPACITY;
`endif
  localparam int unsigned SH_W  = LEN * 8;
  localparam int unsigned PTR_W = (LEN > 1) ? $clog2(LEN) : 1;
  // Counter only ever holds 0..TIMEOUT-1; reaching TIMEOUT is the abort itself.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [SH_W-1:0]   sh_nxt;
  logic [SH_W-1:0]   payload;
  logic [7:0]        o_data_d;
  logic              trig_d, busy_d, error_d;

  // Packet image as loaded: payload bytes, plus the checksum byte on top when enabled.
`ifdef UDP_WRITER_CHKSUM_EN
  logic [7:0] chk;

  always_comb begin
    chk = 8'h00;
    for (int unsigned k = 0; k < CAPACITY; k++) begin
      chk = chk ^ i_data[8*k +: 8];
    end
  end

  assign payload = {chk, i_data};
`else
  assign payload = i_data;
`endif

  assign o_len  = 16'(LEN);
  // Byte 0 of the shifted image is the byte served after the current one.
  assign sh_nxt = sh_q >> 8;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      o_data  <= 8'h00;
      trig    <= 1'b0;
      busy    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      o_data  <= o_data_d;
      trig    <= trig_d;
      busy    <= busy_d;
      error   <= error_d;
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    o_data_d = o_data;
    error_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (read_en) begin
          error_d = 1'b1;
        end
        if (load) begin
          state_d  = S_ARM;
          ptr_d    = '0;
          cnt_d    = '0;
          sh_d     = payload;
          o_data_d = payload[7:0];
        end
      end

      S_ARM, S_SEND: begin
        if (load) begin
          error_d = 1'b1;
        end
        if (state_q == S_ARM) begin
          state_d = S_SEND;
        end
        // A read takes priority over a timeout expiring in the same cycle.
        if (read_en) begin
          cnt_d = '0;
          if (ptr_q == PTR_W'(LEN - 1)) begin
            state_d  = S_IDLE;
            o_data_d = 8'h00;
          end else begin
            ptr_d    = ptr_q + PTR_W'(1);
            sh_d     = sh_nxt;
            o_data_d = sh_nxt[7:0];
          end
        end else if (TIMEOUT != 0) begin
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            o_data_d = 8'h00;
            error_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d  = S_IDLE;
        o_data_d = 8'h00;
      end
    endcase

    trig_d = (state_d == S_ARM);
    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_udp_writer.sv
// Directed self-checking bench for udp_writer (CAPACITY=6, TIMEOUT=10).
// Works with or without UDP_WRITER_CHKSUM_EN; the checksum byte is hand-computed.
module tb_udp_writer;

`ifdef UDP_WRITER_CHKSUM_EN
  localparam int LEN = 7;
`else
  localparam int LEN = 6;
`endif

  logic        clk;
  logic        rstn;
  logic        load;
  logic [47:0] i_data;
  logic        trig;
  logic        read_en;
  logic [7:0]  o_data;
  logic [15:0] o_len;
  logic        busy;
  logic        error;

  int n_checks;
  int n_fail;

  udp_writer #(
    .CAPACITY(6),
    .TIMEOUT (10)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .load   (load),
    .i_data (i_data),
    .trig   (trig),
    .read_en(read_en),
    .o_data (o_data),
    .o_len  (o_len),
    .busy   (busy),
    .error  (error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full packet: exp holds the bytes in send order (byte 6 = checksum when enabled).
  // gap idle cycles precede every read; ovl plants a load in the first gap before byte 2.
  task automatic send_packet(input logic [47:0] data, input logic [55:0] exp,
                             input int gap, input bit ovl);
    i_data = data;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    check_eq("arm_trig", 32'(trig), 32'd1);
    check_eq("arm_busy", 32'(busy), 32'd1);
    check_eq("arm_byte0", 32'(o_data), 32'(exp[7:0]));
    check_eq("arm_err", 32'(error), 32'd0);
    tick();
    check_eq("send_trig", 32'(trig), 32'd0);
    for (int k = 0; k < LEN; k++) begin
      for (int g = 0; g < gap; g++) begin
        if (ovl && k == 2 && g == 0) begin
          load   = 1'b1;
          i_data = 48'hFFFF_FFFF_FFFF;
        end
        tick();
        load = 1'b0;
        check_eq("gap_err", 32'(error), (ovl && k == 2 && g == 0) ? 32'd1 : 32'd0);
        check_eq("gap_busy", 32'(busy), 32'd1);
        check_eq("gap_trig", 32'(trig), 32'd0);
      end
      check_eq("byte", 32'(o_data), 32'(exp[8*k +: 8]));
      read_en = 1'b1;
      tick();
      read_en = 1'b0;
      if (k < LEN - 1) begin
        check_eq("mid_busy", 32'(busy), 32'd1);
        check_eq("mid_trig", 32'(trig), 32'd0);
        check_eq("mid_err", 32'(error), 32'd0);
      end
    end
    check_eq("end_busy", 32'(busy), 32'd0);
    check_eq("end_data", 32'(o_data), 32'd0);
    check_eq("end_err", 32'(error), 32'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk      = 1'b0;
    rstn     = 1'b0;
    load     = 1'b0;
    read_en  = 1'b0;
    i_data   = '0;

    #3;
    check_eq("rst_trig", 32'(trig), 32'd0);
    check_eq("rst_data", 32'(o_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(error), 32'd0);
    check_eq("o_len", 32'(o_len), 32'(LEN));
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Basic send, reads held high from the first SEND cycle.
    send_packet(48'h6655_4433_2211, 56'h77_6655_4433_2211, 0, 1'b0);

    // Gapped reads (every 3rd cycle) with an overlapping load mid-packet.
    send_packet(48'h6050_4030_2010, 56'h70_6050_4030_2010, 2, 1'b1);

    // Stray read in IDLE.
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    check_eq("stray_err", 32'(error), 32'd1);
    check_eq("stray_data", 32'(o_data), 32'd0);
    check_eq("stray_busy", 32'(busy), 32'd0);
    check_eq("stray_trig", 32'(trig), 32'd0);
    tick();
    check_eq("stray_err_clr", 32'(error), 32'd0);

    // Timeout: busy for exactly 10 cycles, then abort with one error pulse.
    i_data = 48'hAABB_CCDD_EEFF;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    check_eq("to_byte0", 32'(o_data), 32'hFF);
    for (int i = 1; i < 10; i++) begin
      check_eq("to_busy", 32'(busy), 32'd1);
      check_eq("to_err", 32'(error), 32'd0);
      tick();
    end
    check_eq("to_busy_last", 32'(busy), 32'd1);
    tick();
    check_eq("to_abort_busy", 32'(busy), 32'd0);
    check_eq("to_abort_err", 32'(error), 32'd1);
    check_eq("to_abort_data", 32'(o_data), 32'd0);
    tick();
    check_eq("to_err_clr", 32'(error), 32'd0);
    send_packet(48'h6655_4433_2211, 56'h77_6655_4433_2211, 0, 1'b0);

    // Reset mid-packet after 3 of 6 bytes.
    i_data = 48'h6655_4433_2211;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    tick();
    read_en = 1'b1;
    tick();
    tick();
    tick();
    read_en = 1'b0;
    check_eq("pre_rst_data", 32'(o_data), 32'h44);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("arst_data", 32'(o_data), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_trig", 32'(trig), 32'd0);
    check_eq("arst_err", 32'(error), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    check_eq("post_rst_trig", 32'(trig), 32'd0);
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    send_packet(48'h0A0B_0C0D_0E0F, 56'h01_0A0B_0C0D_0E0F, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
